// File: rtl/uart_rx_oversampled.sv
`timescale 1ns/1ps
// UART receiver with oversampled 3-point majority voting, configurable word
// format, framing/parity/overrun flags and a valid/ack output handshake.
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int DIV_RAW = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LO   = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_HI   = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Odd mode expects an odd number of ones across data+parity, even mode an even number.
    function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (PAR_MODE)
            2'd1:    parity_bad = ~x;
            2'd2:    parity_bad = x;
            default: parity_bad = 1'b0;
        endcase
    endfunction

    logic [1:0]            sync_q;
    logic                  rxs_s;
    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [SAMP_W-1:0]     samp_q, samp_d;
    logic [1:0]            vote_q, vote_d;
    logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
    logic                  stopcnt_q, stopcnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  tick_s, mid_s, end_s, maj_s, complete_s;

    assign rxs_s  = sync_q[1];
    assign tick_s = (div_q == DIV_LAST);
    assign mid_s  = tick_s && (samp_q == SAMP_HI);
    assign end_s  = tick_s && (samp_q == SAMP_LAST);
    assign maj_s  = majority3(vote_q[1], vote_q[0], rxs_s);

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Next-state, sampling and output-handshake logic.
    always_comb begin
        state_d    = state_q;
        div_d      = (state_q == S_IDLE || tick_s) ? '0 : div_q + DIV_W'(1);
        samp_d     = samp_q;
        vote_d     = vote_q;
        bitcnt_d   = bitcnt_q;
        stopcnt_d  = stopcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        armed_d    = armed_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        complete_s = 1'b0;

        if (state_q == S_IDLE) begin
            samp_d = '0;
        end else if (tick_s) begin
            samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SAMP_W'(1);
        end else begin
            samp_d = samp_q;
        end

        if (tick_s && (samp_q == SAMP_LO || samp_q == SAMP_MID)) begin
            vote_d = {vote_q[0], rxs_s};
        end else begin
            vote_d = vote_q;
        end

        case (state_q)
            S_IDLE: begin
                // A start edge counts only after the line has been seen high (break lockout).
                if (rxs_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d    = 1'b0;
                    ferr_acc_d = 1'b0;
                    state_d    = S_START;
                end else begin
                    armed_d = armed_q;
                end
            end
            S_START: begin
                if (mid_s && maj_s) begin
                    state_d = S_IDLE;
                end else if (end_s) begin
                    bitcnt_d = '0;
                    state_d  = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (mid_s) begin
                    shreg_d  = {maj_s, shreg_q[DATA_WIDTH-1:1]};
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                end else if (end_s && bitcnt_q == BIT_LAST) begin
                    stopcnt_d  = 1'b0;
                    ferr_acc_d = 1'b0;
                    state_d    = (PAR_MODE != 2'd0) ? S_PARITY : S_STOP;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (mid_s) begin
                    par_d = maj_s;
                end else if (end_s) begin
                    stopcnt_d = 1'b0;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                // The word completes mid-way through the last stop bit so a following start edge is never missed.
                if (mid_s && stopcnt_q == STOP_LAST) begin
                    complete_s = 1'b1;
                    armed_d    = 1'b0;
                    state_d    = S_IDLE;
                end else if (mid_s) begin
                    ferr_acc_d = ferr_acc_q | ~maj_s;
                end else if (end_s) begin
                    stopcnt_d = ~stopcnt_q;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete_s) begin
            data_d  = shreg_q;
            perr_d  = parity_bad(shreg_q, par_q);
            ferr_d  = ferr_acc_q | ~maj_s;
            valid_d = 1'b1;
            if (valid_q && !data_ack) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (valid_q && data_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            samp_q     <= '0;
            vote_q     <= 2'b00;
            bitcnt_q   <= '0;
            stopcnt_q  <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            armed_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            samp_q     <= samp_d;
            vote_q     <= vote_d;
            bitcnt_q   <= bitcnt_d;
            stopcnt_q  <= stopcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
`timescale 1ns/1ps
// Directed bench: four receivers (8N1, 8E1, 5N2, 9O2) at 115200 baud on a
// 50 MHz clock, each on its own line, driven by an ideal-timing frame model.
module tb_uart_rx_oversampled;

    localparam real BT = 1.0e9 / 115200.0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drv = 1'b1;
    int   line_sel = 0;
    logic rx0, rx1, rx2, rx3;
    logic ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0, ack3 = 1'b0;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [8:0] d3;
    logic v0, v1, v2, v3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3, ov0, ov1, ov2, ov3;
    int checks = 0;
    int errors = 0;
    int n_lat = 0;

    assign rx0 = (line_sel == 0) ? rx_drv : 1'b1;
    assign rx1 = (line_sel == 1) ? rx_drv : 1'b1;
    assign rx2 = (line_sel == 2) ? rx_drv : 1'b1;
    assign rx3 = (line_sel == 3) ? rx_drv : 1'b1;

    always #10 clk = ~clk;

    uart_rx_oversampled #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_WIDTH(8),
                          .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data(d0), .data_valid(v0), .data_ack(ack0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0));
    uart_rx_oversampled #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_WIDTH(8),
                          .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data(d1), .data_valid(v1), .data_ack(ack1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1));
    uart_rx_oversampled #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_WIDTH(5),
                          .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .data(d2), .data_valid(v2), .data_ack(ack2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2));
    uart_rx_oversampled #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_WIDTH(9),
                          .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .rx(rx3), .data(d3), .data_valid(v3), .data_ack(ack3),
        .parity_err(pe3), .frame_err(fe3), .overrun(ov3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // par < 0 means no parity bit; only the last stop bit takes stop_val.
    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input int par,
                              input int nstop, input logic stop_val, input real bt);
        line_sel = sel;
        rx_drv = 1'b0;
        #(bt);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = d[i];
            #(bt);
        end
        if (par >= 0) begin
            rx_drv = (par != 0);
            #(bt);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_drv = (i == nstop - 1) ? stop_val : 1'b1;
            #(bt);
        end
        rx_drv = 1'b1;
        #(bt);
    endtask

    task automatic ack_pulse(input int sel);
        @(negedge clk);
        case (sel)
            0: ack0 = 1'b1;
            1: ack1 = 1'b1;
            2: ack2 = 1'b1;
            default: ack3 = 1'b1;
        endcase
        @(negedge clk);
        ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0; ack3 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_data0", d0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_perr0", pe0, 0);
        chk("rst_ferr0", fe0, 0);
        chk("rst_ovr0", ov0, 0);
        chk("rst_valid_others", {v1, v2, v3}, 0);

        // Plain 8N1 word and ack
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, BT);
        chk("t1_data", d0, 8'hA5);
        chk("t1_valid", v0, 1);
        chk("t1_perr", pe0, 0);
        chk("t1_ferr", fe0, 0);
        chk("t1_ovr", ov0, 0);
        ack_pulse(0);
        chk("t1_valid_after_ack", v0, 0);
        chk("t1_data_hold", d0, 8'hA5);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
        send_frame(1, 9'h003, 8, 1, 1, 1'b1, BT);
        chk("t2_data", d1, 8'h03);
        chk("t2_perr_bad", pe1, 1);
        chk("t2_valid", v1, 1);
        ack_pulse(1);
        send_frame(1, 9'h003, 8, 0, 1, 1'b1, BT);
        chk("t2_perr_good", pe1, 0);
        chk("t2_ferr", fe1, 0);
        ack_pulse(1);

        // Stop bit 0 and a long break
        send_frame(0, 9'h03C, 8, -1, 1, 1'b0, BT);
        chk("t3_data", d0, 8'h3C);
        chk("t3_ferr", fe0, 1);
        ack_pulse(0);
        line_sel = 0;
        rx_drv = 1'b0;
        #(BT * 20.0);
        rx_drv = 1'b1;
        #(BT * 3.0);
        chk("t3_brk_valid", v0, 1);
        chk("t3_brk_data", d0, 0);
        chk("t3_brk_ferr", fe0, 1);
        chk("t3_brk_one_word", ov0, 0);
        ack_pulse(0);
        send_frame(0, 9'h055, 8, -1, 1, 1'b1, BT);
        chk("t3_after_data", d0, 8'h55);
        chk("t3_after_ferr", fe0, 0);
        chk("t3_after_ovr", ov0, 0);
        ack_pulse(0);

        // Start-bit glitch and baud skew
        rx_drv = 1'b0;
        #(1000);
        rx_drv = 1'b1;
        #(BT * 12.0);
        chk("t4_glitch_valid", v0, 0);
        send_frame(0, 9'h0C3, 8, -1, 1, 1'b1, BT * 1.03);
        chk("t4_slow_data", d0, 8'hC3);
        chk("t4_slow_errs", {pe0, fe0}, 0);
        ack_pulse(0);
        send_frame(0, 9'h0C3, 8, -1, 1, 1'b1, BT * 0.97);
        chk("t4_fast_data", d0, 8'hC3);
        chk("t4_fast_errs", {pe0, fe0}, 0);
        chk("t4_fast_valid", v0, 1);
        ack_pulse(0);

        // Overrun, then ack landing in the completion cycle
        send_frame(0, 9'h011, 8, -1, 1, 1'b1, BT);
        chk("t5_first", d0, 8'h11);
        @(negedge clk);
        n_lat = 0;
        fork
            send_frame(0, 9'h022, 8, -1, 1, 1'b1, BT);
            begin
                while (d0 !== 8'h22 && n_lat < 20000) begin
                    @(negedge clk);
                    n_lat++;
                end
            end
        join
        chk("t5_second_seen", (n_lat < 20000), 1);
        chk("t5_data", d0, 8'h22);
        chk("t5_ovr", ov0, 1);
        chk("t5_valid", v0, 1);
        ack_pulse(0);
        chk("t5_ack_valid", v0, 0);
        chk("t5_ack_ovr", ov0, 0);
        send_frame(0, 9'h011, 8, -1, 1, 1'b1, BT);
        chk("t5b_first_ovr", ov0, 0);
        @(negedge clk);
        fork
            send_frame(0, 9'h022, 8, -1, 1, 1'b1, BT);
            begin
                repeat (n_lat - 1) @(negedge clk);
                ack0 = 1'b1;
                @(negedge clk);
                ack0 = 1'b0;
            end
        join
        chk("t5b_data", d0, 8'h22);
        chk("t5b_valid", v0, 1);
        chk("t5b_ovr", ov0, 0);

        // Width / stop-bit sweep
        send_frame(2, 9'h016, 5, -1, 2, 1'b1, BT);
        chk("w5_data", d2, 5'h16);
        chk("w5_errs", {pe2, fe2, ov2}, 0);
        ack_pulse(2);
        send_frame(2, 9'h009, 5, -1, 2, 1'b0, BT);
        chk("w5_stop2_data", d2, 5'h09);
        chk("w5_stop2_ferr", fe2, 1);
        ack_pulse(2);
        send_frame(3, 9'h1A5, 9, 0, 2, 1'b1, BT);
        chk("w9_data", d3, 9'h1A5);
        chk("w9_odd_ok", {pe3, fe3}, 0);
        ack_pulse(3);
        send_frame(3, 9'h1A5, 9, 1, 2, 1'b1, BT);
        chk("w9_odd_bad", pe3, 1);
        ack_pulse(3);

        // Reset during bit 4 of a frame whose remaining bits are all 1
        @(negedge clk);
        fork
            send_frame(0, 9'h0F5, 8, -1, 1, 1'b1, BT);
            begin
                #(BT * 5.3);
                rst_n = 1'b0;
                #1;
                chk("t6_rst_data", d0, 0);
                chk("t6_rst_valid", v0, 0);
                chk("t6_rst_flags", {pe0, fe0, ov0}, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        chk("t6_no_partial", v0, 0);
        send_frame(0, 9'h05A, 8, -1, 1, 1'b1, BT);
        chk("t6_data", d0, 8'h5A);
        chk("t6_valid", v0, 1);
        chk("t6_flags", {pe0, fe0, ov0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
